// File: rtl/gfx_pkg.sv
// gfx_pkg: shared colour and XGA timing constants for the draw pipeline
package gfx_pkg;
  localparam int RGB_W = 12;
  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'h0F0;
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_V_ACTIVE = 768;
  localparam int GFX_CNT_W = 11;
endpackage

// File: rtl/layer_addr_gen.sv
// layer_addr_gen: stage-1 hit test and ROM address for a single layer
module layer_addr_gen
  import gfx_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int ADDR_W = 12,
  parameter int CNT_W = GFX_CNT_W
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              en,
  input  logic              tile,
  input  logic [CNT_W-1:0]  xpos,
  input  logic [CNT_W-1:0]  ypos,
  input  logic [CNT_W-1:0]  hcount,
  input  logic [CNT_W-1:0]  vcount,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              hit
);
  localparam int WB = $clog2(IMG_W);
  localparam int HB = $clog2(IMG_H);
  localparam logic [CNT_W:0] IW = (CNT_W+1)'(IMG_W);
  localparam logic [CNT_W:0] IH = (CNT_W+1)'(IMG_H);
  logic [CNT_W-1:0] rx, ry;
  logic in_x, in_y;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic hit_d, hit_q;
  // Offsets wrap modulo the image in both modes; the extra sum bit keeps edge sprites from wrapping
  always_comb begin
    rx = hcount - xpos;
    ry = vcount - ypos;
    in_x = {1'b0, hcount} >= {1'b0, xpos} && {1'b0, hcount} < {1'b0, xpos} + IW;
    in_y = {1'b0, vcount} >= {1'b0, ypos} && {1'b0, vcount} < {1'b0, ypos} + IH;
    hit_d = en && (tile || (in_x && in_y));
    addr_d = {ry[HB-1:0], rx[WB-1:0]};
  end
  // Register address toward the ROM and the hit flag that travels with it
  always_ff @(posedge pclk) begin
    if (!rst) begin
      addr_q <= '0;
      hit_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      hit_q <= hit_d;
    end
  end
  assign pixel_addr = addr_q;
  assign hit = hit_q;
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: N-layer priority compositor with colour-key transparency over an XGA stream
module layer_compositor
  import gfx_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int ADDR_W = 12,
  parameter int CNT_W = GFX_CNT_W,
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter logic [RGB_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic [CNT_W-1:0]             hcount_in,
  input  logic [CNT_W-1:0]             vcount_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         hblnk_in,
  input  logic                         vblnk_in,
  input  logic [RGB_W-1:0]             rgb_in,
  input  logic [NUM_LAYERS-1:0]        layer_en,
  input  logic [NUM_LAYERS-1:0]        layer_tile,
  input  logic [NUM_LAYERS*CNT_W-1:0]  xpos,
  input  logic [NUM_LAYERS*CNT_W-1:0]  ypos,
  output logic [NUM_LAYERS*ADDR_W-1:0] pixel_addr,
  input  logic [NUM_LAYERS*RGB_W-1:0]  rgb_pixel,
  output logic [CNT_W-1:0]             hcount_out,
  output logic [CNT_W-1:0]             vcount_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic                         hblnk_out,
  output logic                         vblnk_out,
  output logic [RGB_W-1:0]             rgb_out,
  output logic                         frame_ended
);
  localparam int TW = 2*CNT_W + 4 + RGB_W;
  logic [NUM_LAYERS-1:0] en_d, en_q, tile_d, tile_q, hit1, hit2_d, hit2_q;
  logic [NUM_LAYERS*CNT_W-1:0] xpos_d, xpos_q, ypos_d, ypos_q;
  logic [TW-1:0] t1_d, t1_q, t2_d, t2_q;
  logic [TW-RGB_W-1:0] t3_d, t3_q;
  logic [RGB_W-1:0] rgb_d, rgb_q;
  logic fe_d, fe_q, cap;
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    layer_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_gen (
      .pclk(pclk), .rst(rst), .en(en_q[i]), .tile(tile_q[i]),
      .xpos(xpos_q[i*CNT_W +: CNT_W]), .ypos(ypos_q[i*CNT_W +: CNT_W]),
      .hcount(hcount_in), .vcount(vcount_in),
      .pixel_addr(pixel_addr[i*ADDR_W +: ADDR_W]), .hit(hit1[i])
    );
  end
  // Layer settings latch only at the start of vertical blank so a frame never tears
  always_comb begin
    cap = hcount_in == '0 && vcount_in == CNT_W'(V_ACTIVE);
    en_d = cap ? layer_en : en_q;
    tile_d = cap ? layer_tile : tile_q;
    xpos_d = cap ? xpos : xpos_q;
    ypos_d = cap ? ypos : ypos_q;
  end
  // Timing/background delay line; stage 2 lines up with the ROM data
  always_comb begin
    t1_d = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
    t2_d = t1_q;
    hit2_d = hit1;
    t3_d = t2_q[TW-1:RGB_W];
    fe_d = t2_q[TW-1 -: CNT_W] == CNT_W'(H_ACTIVE - 1) && t2_q[TW-CNT_W-1 -: CNT_W] == CNT_W'(V_ACTIVE - 1);
  end
  // Priority mux: later (higher-index) opaque layers overwrite earlier ones; blanking forces black
  always_comb begin
    rgb_d = t2_q[RGB_W-1:0];
    for (int k = 0; k < NUM_LAYERS; k++)
      if (hit2_q[k] && rgb_pixel[k*RGB_W +: RGB_W] != KEY_COLOR) rgb_d = rgb_pixel[k*RGB_W +: RGB_W];
    rgb_d = (t2_q[RGB_W+1] || t2_q[RGB_W]) ? '0 : rgb_d;
  end
  // Pipeline and shadow registers
  always_ff @(posedge pclk) begin
    if (!rst) begin
      en_q <= '0;
      tile_q <= '0;
      xpos_q <= '0;
      ypos_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      t3_q <= '0;
      hit2_q <= '0;
      rgb_q <= '0;
      fe_q <= 1'b0;
    end else begin
      en_q <= en_d;
      tile_q <= tile_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      t3_q <= t3_d;
      hit2_q <= hit2_d;
      rgb_q <= rgb_d;
      fe_q <= fe_d;
    end
  end
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = t3_q;
  assign rgb_out = rgb_q;
  assign frame_ended = fe_q;
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: randomized scoreboard bench against a pixel-level reference model
module tb_layer_compositor;
  localparam int NL = 4;
  localparam int CW = 11;
  localparam int AW = 12;
  localparam logic [11:0] KEY = 12'h0F0;

  logic pclk = 1'b0;
  logic rst = 1'b0;
  logic [CW-1:0] hcount_in = '0, vcount_in = '0;
  logic hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [NL-1:0] layer_en = '0, layer_tile = '0;
  logic [NL*CW-1:0] xpos = '0, ypos = '0;
  logic [NL*AW-1:0] pixel_addr;
  logic [NL*12-1:0] rgb_pixel = '0;
  logic [CW-1:0] hcount_out, vcount_out;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out, frame_ended;
  logic [11:0] rgb_out;

  layer_compositor dut (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .layer_en(layer_en), .layer_tile(layer_tile), .xpos(xpos), .ypos(ypos),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .frame_ended(frame_ended)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int due;
    logic [CW-1:0] h, v;
    logic hs, vs, hb, vb, fe;
    logic [11:0] rgb;
  } exp_t;
  typedef struct {
    int due;
    logic [NL*AW-1:0] addr;
  } aexp_t;
  exp_t oq[$];
  aexp_t aq[$];

  logic [11:0] mem [NL][4096];
  int cyc = 0;
  int passed = 0, total = 0;
  bit [NL-1:0] r_en = '0, r_tile = '0, s_en = '0, s_tile = '0;
  int r_x[NL], r_y[NL], s_x[NL], s_y[NL];
  bit bg_fixed = 0;
  logic [11:0] bg_val = '0;

  always @(posedge pclk) cyc <= cyc + 1;

  // External 1-cycle-latency image ROMs
  always @(posedge pclk)
    for (int i = 0; i < NL; i++) rgb_pixel[i*12 +: 12] <= mem[i][pixel_addr[i*AW +: AW]];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
  endfunction

  exp_t me;
  aexp_t ma;
  always @(negedge pclk) begin
    while (aq.size() > 0 && aq[0].due == cyc) begin
      ma = aq.pop_front();
      chk("pixel_addr", 64'(pixel_addr), 64'(ma.addr));
    end
    while (oq.size() > 0 && oq[0].due == cyc) begin
      me = oq.pop_front();
      chk("rgb_out", 64'(rgb_out), 64'(me.rgb));
      chk("hcount_out", 64'(hcount_out), 64'(me.h));
      chk("vcount_out", 64'(vcount_out), 64'(me.v));
      chk("sync_blank", 64'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 64'({me.hs, me.vs, me.hb, me.vb}));
      chk("frame_ended", 64'(frame_ended), 64'(me.fe));
    end
  end

  // Drive one pixel and queue what the outputs must show for it
  task automatic drive(int h, int v, bit rstn);
    exp_t e;
    aexp_t a;
    int ad[NL];
    bit hit;
    @(posedge pclk);
    #1;
    rst = rstn;
    hcount_in = CW'(h);
    vcount_in = CW'(v);
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
    hblnk_in = h >= 1024;
    vblnk_in = v >= 768;
    rgb_in = bg_fixed ? bg_val : 12'($urandom);
    layer_en = r_en;
    layer_tile = r_tile;
    for (int i = 0; i < NL; i++) begin
      xpos[i*CW +: CW] = CW'(r_x[i]);
      ypos[i*CW +: CW] = CW'(r_y[i]);
    end
    a.due = cyc + 1;
    a.addr = '0;
    e.due = cyc + 1;
    e.h = '0; e.v = '0; e.hs = 0; e.vs = 0; e.hb = 0; e.vb = 0; e.fe = 0; e.rgb = '0;
    if (!rstn) begin
      s_en = '0; s_tile = '0;
      for (int i = 0; i < NL; i++) begin s_x[i] = 0; s_y[i] = 0; end
    end else begin
      e.due = cyc + 3;
      e.h = hcount_in; e.v = vcount_in; e.hs = hsync_in; e.vs = vsync_in;
      e.hb = hblnk_in; e.vb = vblnk_in;
      e.fe = h == 1023 && v == 767;
      e.rgb = rgb_in;
      for (int i = 0; i < NL; i++) begin
        ad[i] = (((v - s_y[i]) % 64 + 64) % 64) * 64 + (((h - s_x[i]) % 64 + 64) % 64);
        a.addr[i*AW +: AW] = AW'(ad[i]);
      end
      for (int i = NL - 1; i >= 0; i--) begin
        hit = s_en[i] && (s_tile[i] || (h >= s_x[i] && h < s_x[i] + 64 && v >= s_y[i] && v < s_y[i] + 64));
        if (hit && mem[i][ad[i]] != KEY) begin
          e.rgb = mem[i][ad[i]];
          break;
        end
      end
      if (e.hb || e.vb) e.rgb = '0;
      if (h == 0 && v == 768) begin
        s_en = r_en; s_tile = r_tile;
        for (int i = 0; i < NL; i++) begin s_x[i] = r_x[i]; s_y[i] = r_y[i]; end
      end
    end
    aq.push_back(a);
    oq.push_back(e);
  endtask

  task automatic run(int h0, int v, int n);
    for (int j = 0; j < n; j++) drive(h0 + j, v, 1);
  endtask

  task automatic capture();
    drive(0, 768, 1);
  endtask

  task automatic idle();
    run(1100, 800, 4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t z;
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < 4096; j++) mem[i][j] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    for (int i = 0; i < NL; i++) begin
      r_x[i] = $urandom_range(0, 400); r_y[i] = $urandom_range(0, 400); s_x[i] = 0; s_y[i] = 0;
    end
    r_en = '1;
    // Reset with live stimulus, including a would-be capture point
    for (int k = 0; k < 5; k++) drive(k == 2 ? 0 : $urandom_range(0, 1000), k == 2 ? 768 : $urandom_range(0, 700), 0);
    z.h = '0; z.v = '0; z.hs = 0; z.vs = 0; z.hb = 0; z.vb = 0; z.fe = 0; z.rgb = '0;
    z.due = cyc + 2; oq.push_back(z);
    z.due = cyc + 3; oq.push_back(z);
    for (int i = 0; i < NL; i++) begin r_x[i] = 300 + 4 * i; r_y[i] = 40; end
    run(300, 40, 20);
    bg_fixed = 1; bg_val = 12'hABC;
    run(98, 100, 5);
    bg_fixed = 0;
    r_en = 4'b0001; r_tile = '0; r_x[0] = 200; r_y[0] = 300;
    capture();
    run(195, 303, 75);
    idle();
    r_en = 4'b0101; r_x[2] = 200; r_y[2] = 300;
    capture();
    idle();
    mem[2][197] = KEY; mem[0][197] = 12'hF00;
    run(204, 303, 3);
    idle();
    mem[2][197] = 12'h00F;
    run(204, 303, 3);
    idle();
    r_en = 4'b0010; r_tile = 4'b0010; r_x[1] = 0; r_y[1] = 0;
    capture();
    run(60, 0, 8);
    run(1018, 0, 12);
    r_en = 4'b1000; r_tile = '0; r_x[3] = 1000; r_y[3] = 10;
    capture();
    run(1015, 20, 12);
    run(0, 20, 45);
    r_x[3] = 500;
    run(995, 20, 10);
    run(495, 20, 10);
    capture();
    run(495, 20, 10);
    run(995, 20, 10);
    run(1018, 766, 8);
    run(1018, 767, 10);
    // Randomized configurations, sometimes changed without a capture
    for (int it = 0; it < 40; it++) begin
      r_en = 4'($urandom); r_tile = 4'($urandom);
      for (int i = 0; i < NL; i++) begin r_x[i] = $urandom_range(0, 1099); r_y[i] = $urandom_range(0, 799); end
      if ($urandom_range(0, 2) != 0) capture();
      run($urandom_range(0, 1280), $urandom_range(0, 805), $urandom_range(20, 60));
      if (it % 10 == 0) run(1000, 767, 30);
    end
    repeat (5) @(posedge pclk);
    @(negedge pclk);
    chk("scoreboard_drained", 64'(oq.size() + aq.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
